tx_frame_serializer: RTL and testbench
======================================

Name: tx_frame_serializer

Overview:
Downstream stage of the TX FIFO in the F2F TX path. Pulls DATA_WIDTH-bit words from the FIFO head and builds frames: 16-bit sync pattern, FRAME_WORDS payload words, then CRC-16. Each frame is sent MSB-first, one bit per clock, to the SERDES lane. Uses the FIFO command port to commit an acknowledged frame or rewind it for resend.

Parameters:
DATA_WIDTH, 32, payload word width; must match the FIFO data width.
FRAME_WORDS, 4, payload words per frame (≥1).
SYNC_PATTERN, 16'hF0A5, frame preamble; not covered by the CRC.
ACK_TIMEOUT, 1024, cycles in WAIT_ACK before the frame is treated as a NACK.
MAX_RETRIES, 3, resends per frame before it is dropped.

Ports:
clk  in  1  single clock
reset_n  in  1  synchronous, active-low reset
enable  in  1  allows a new frame to start; sampled only in IDLE
fifo_dout  in  DATA_WIDTH  FIFO head word; registered, valid 2 cycles after any fifo_rd_en or fifo_command
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  one-cycle pop pulse
fifo_command  out  4  0 = none, 1 = commit, 2 = resend; one-cycle pulses
ack_valid  in  1  link-partner response strobe
ack_ok  in  1  qualifies ack_valid: 1 = CRC good, 0 = NACK
tx_bit  out  1  serial data
tx_valid  out  1  tx_bit is a frame bit
tx_sof  out  1  high with the first sync bit
frame_sent  out  1  pulse on commit after ACK
retry_err  out  1  pulse when a frame is dropped after MAX_RETRIES
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; CRC register 16'hFFFF.
- CRC is CRC-16/CCITT-FALSE: poly 0x1021, init 0xFFFF, no reflection, no final XOR. It is updated bit-serially over payload bits only, in transmit order.
- IDLE: tx_valid = 0. If enable && !fifo_empty, go to SYNC next cycle, init CRC, clear word_cnt.
- SYNC: 16 cycles, tx_bit = SYNC_PATTERN MSB-first, tx_valid = 1, tx_sof on the first cycle only. Then go to LOAD.
- LOAD: tx_valid = 0.
  - If fifo_empty: stall here; tx_bit = 0, CRC held.
  - Else: capture fifo_dout into the shift register, pulse fifo_rd_en for one cycle, go to DATA.
- DATA: DATA_WIDTH cycles, tx_valid = 1, MSB-first, CRC updated each bit. After the last bit, word_cnt+1. Go to CRC if word_cnt reached FRAME_WORDS-1, else LOAD.
- CRC: 16 cycles shifting out the frozen CRC MSB-first, tx_valid = 1. Then go to WAIT_ACK with the timeout counter at 0.
- WAIT_ACK: tx_valid = 0; timeout counter increments every cycle.
  - ack_valid && ack_ok: go to CMD with commit, clear retry_cnt, frame_sent pulses in CMD.
  - ack_valid && !ack_ok, or counter == ACK_TIMEOUT-1: NACK.
  - ack_valid and timeout in the same cycle: ack_valid wins.
- NACK handling:
  - retry_cnt < MAX_RETRIES: retry_cnt+1, go to CMD with resend.
  - Otherwise: CMD with commit (frame dropped), retry_err pulse, retry_cnt cleared.
- CMD: fifo_command = selected code for 1 cycle, then SETTLE.
- SETTLE: 1 cycle so fifo_dout reflects the rewound or committed pointer, then IDLE.
- A resend starts a new frame through the normal IDLE path and requires enable.
- ack_valid is ignored in every state except WAIT_ACK.
- enable deasserted mid-frame: the current frame completes.
- fifo_empty is sampled only in IDLE and LOAD.
- Default frame timing, no stalls: tx_valid high for 16 + 4*32 + 16 = 160 cycles over 164 cycles from SYNC entry to WAIT_ACK entry (4 LOAD gaps).
- Reset mid-frame: immediate return to reset values next cycle. No command is issued, so already-popped words are committed or rewound only by the FIFO's own reset.
- Counters: bit_cnt clog2(DATA_WIDTH) bits wide (min 4 so it can count the 16 SYNC/CRC bits), word_cnt clog2(FRAME_WORDS+1), retry_cnt clog2(MAX_RETRIES+1), timeout clog2(ACK_TIMEOUT). All wrap-free by construction.

Decomposition:
- Package tx_serdes_pkg:
  - state enum (IDLE, SYNC, LOAD, DATA, CRC, WAIT_ACK, CMD, SETTLE);
  - CMD_NONE/CMD_COMMIT/CMD_RESEND = 4'd0/1/2;
  - CRC16_POLY = 16'h1021, CRC16_INIT = 16'hFFFF.
- Sub-module crc16_ccitt_serial, with ports clk, reset_n, init, en, bit_in, crc[15:0]: one bit per enabled cycle.

Test Plan:
1. DATA_WIDTH=8, FRAME_WORDS=9, FIFO preloaded with 0x31..0x39, enable=1 -> sync 0xF0A5, then bytes 0x31..0x39 MSB-first, then CRC 0x29B1; exactly 9 fifo_rd_en pulses.
2. Defaults with 4 words queued -> tx_sof once; 160 tx_valid cycles within 164 cycles; WAIT_ACK entered. ack_valid=1, ack_ok=1 -> fifo_command=1 for 1 cycle, frame_sent pulse, IDLE 2 cycles later.
3. FIFO holds 2 of 4 words -> stall in LOAD with tx_valid=0 and CRC held. Push the remaining 2 words 50 cycles later -> frame resumes; CRC equals the unstalled result.
4. NACK (ack_ok=0) -> fifo_command=2, identical frame retransmitted. ACK the second copy -> commit, retry_cnt=0.
5. No ack_valid -> timeout after 1024 cycles -> resend. Four consecutive NACK/timeouts -> 4th issues command 1, retry_err pulse, next frame uses new data.
6. reset_n=0 during DATA word 2 -> next cycle all outputs 0, busy=0. ack_valid in IDLE -> no command issued.

Source files
------------

// File: rtl/tx_frame_serializer_pkg.sv
// Shared types and constants for the F2F TX frame serializer: FSM states,
// FIFO command codes and the CRC-16/CCITT-FALSE single-bit update.
package tx_serdes_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC     = 3'd1,
    LOAD     = 3'd2,
    DATA     = 3'd3,
    CRC      = 3'd4,
    WAIT_ACK = 3'd5,
    CMD      = 3'd6,
    SETTLE   = 3'd7
  } state_t;

  localparam logic [3:0] CMD_NONE   = 4'd0;
  localparam logic [3:0] CMD_COMMIT = 4'd1;
  localparam logic [3:0] CMD_RESEND = 4'd2;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // MSB-first, non-reflected shift: feedback is the outgoing MSB XOR the new bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                             input logic        bit_in);
    logic        fb;
    logic [15:0] nxt;
    fb  = crc_in[15] ^ bit_in;
    nxt = {crc_in[14:0], 1'b0};
    if (fb) begin
      nxt = nxt ^ CRC16_POLY;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tx_frame_serializer_if.sv
// FIFO-head port between the TX FIFO and the frame serializer.
// fifo_rd_en and fifo_command are one-cycle pulses from the serializer; the FIFO
// presents the new head on fifo_dout two cycles after either, and fifo_empty
// is only trusted by the serializer while it is idle or waiting for a word.
interface tx_frame_serializer_if #(
  parameter int DATA_WIDTH = 32
);
  import tx_serdes_pkg::*;

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [3:0]            fifo_command;

  modport master (
    input  fifo_dout,
    input  fifo_empty,
    output fifo_rd_en,
    output fifo_command
  );

  modport slave (
    output fifo_dout,
    output fifo_empty,
    input  fifo_rd_en,
    input  fifo_command
  );

endinterface

// File: rtl/tx_frame_serializer_crc.sv
// Bit-serial CRC-16/CCITT-FALSE register: init has priority over en,
// one payload bit is folded in per enabled cycle.
module crc16_ccitt_serial
  import tx_serdes_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = crc16_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/tx_frame_serializer.sv
// Pulls payload words from the TX FIFO head and sends sync + payload + CRC-16
// MSB-first on one serial lane, then commits or rewinds the frame on ACK/NACK.
module tx_frame_serializer
  import tx_serdes_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          FRAME_WORDS  = 4,
  parameter logic [15:0] SYNC_PATTERN = 16'hF0A5,
  parameter int          ACK_TIMEOUT  = 1024,
  parameter int          MAX_RETRIES  = 3
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  tx_frame_serializer_if.master fifo,
  input  logic                  ack_valid,
  input  logic                  ack_ok,
  output logic                  tx_bit,
  output logic                  tx_valid,
  output logic                  tx_sof,
  output logic                  frame_sent,
  output logic                  retry_err,
  output logic                  busy,
  output state_t                dbg_state,
  output logic [7:0]            dbg_retry_cnt
);

  // bit_cnt must also count the 16 sync and CRC bits, hence the 4-bit floor.
  localparam int BIT_W = ($clog2(DATA_WIDTH) < 4) ? 4 : $clog2(DATA_WIDTH);
  localparam int WC_W  = ($clog2(FRAME_WORDS + 1) < 1) ? 1 : $clog2(FRAME_WORDS + 1);
  localparam int RC_W  = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam int TO_W  = ($clog2(ACK_TIMEOUT) < 1) ? 1 : $clog2(ACK_TIMEOUT);

  localparam logic [BIT_W-1:0] BIT_LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_LAST_16   = BIT_W'(15);
  localparam logic [WC_W-1:0]  WORD_LAST     = WC_W'(FRAME_WORDS - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX     = RC_W'(MAX_RETRIES);
  localparam logic [TO_W-1:0]  TIMEOUT_LAST  = TO_W'(ACK_TIMEOUT - 1);

  state_t                state_q,    state_d;
  logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [WC_W-1:0]       word_cnt_q, word_cnt_d;
  logic [RC_W-1:0]       retry_cnt_q, retry_cnt_d;
  logic [TO_W-1:0]       timeout_q,  timeout_d;
  logic [DATA_WIDTH-1:0] shift_q,    shift_d;
  logic [3:0]            cmd_q,      cmd_d;
  logic                  drop_q,     drop_d;

  logic        crc_init;
  logic        crc_en;
  logic [15:0] crc_val;
  logic [3:0]  bit_idx;
  logic        rd_en;
  logic [3:0]  command;

  // The 16-bit fields go out MSB-first, so the pattern index is 15 - bit_cnt.
  assign bit_idx = 4'd15 - bit_cnt_q[3:0];

  crc16_ccitt_serial u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (crc_init),
    .en      (crc_en),
    .bit_in  (shift_q[DATA_WIDTH-1]),
    .crc     (crc_val)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    retry_cnt_d = retry_cnt_q;
    timeout_d   = timeout_q;
    shift_d     = shift_q;
    cmd_d       = cmd_q;
    drop_d      = drop_q;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    tx_bit      = 1'b0;
    tx_valid    = 1'b0;
    tx_sof      = 1'b0;
    frame_sent  = 1'b0;
    retry_err   = 1'b0;
    rd_en       = 1'b0;
    command     = CMD_NONE;

    unique case (state_q)
      IDLE: begin
        if (enable && !fifo.fifo_empty) begin
          state_d    = SYNC;
          crc_init   = 1'b1;
          word_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      SYNC: begin
        tx_valid  = 1'b1;
        tx_bit    = SYNC_PATTERN[bit_idx];
        tx_sof    = (bit_cnt_q == '0);
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_LAST_16) begin
          bit_cnt_d = '0;
          state_d   = LOAD;
        end
      end

      LOAD: begin
        if (!fifo.fifo_empty) begin
          shift_d   = fifo.fifo_dout;
          rd_en     = 1'b1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end

      DATA: begin
        tx_valid  = 1'b1;
        tx_bit    = shift_q[DATA_WIDTH-1];
        crc_en    = 1'b1;
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_LAST_DATA) begin
          bit_cnt_d  = '0;
          word_cnt_d = word_cnt_q + WC_W'(1);
          state_d    = (word_cnt_q == WORD_LAST) ? CRC : LOAD;
        end
      end

      CRC: begin
        tx_valid  = 1'b1;
        tx_bit    = crc_val[bit_idx];
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_LAST_16) begin
          bit_cnt_d = '0;
          timeout_d = '0;
          state_d   = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        timeout_d = timeout_q + TO_W'(1);
        // A real response in the timeout cycle takes precedence over the timeout.
        if (ack_valid && ack_ok) begin
          state_d     = CMD;
          cmd_d       = CMD_COMMIT;
          drop_d      = 1'b0;
          retry_cnt_d = '0;
          timeout_d   = '0;
        end else if (ack_valid || (timeout_q == TIMEOUT_LAST)) begin
          state_d   = CMD;
          timeout_d = '0;
          if (retry_cnt_q < RETRY_MAX) begin
            retry_cnt_d = retry_cnt_q + RC_W'(1);
            cmd_d       = CMD_RESEND;
            drop_d      = 1'b0;
          end else begin
            retry_cnt_d = '0;
            cmd_d       = CMD_COMMIT;
            drop_d      = 1'b1;
          end
        end
      end

      CMD: begin
        command    = cmd_q;
        frame_sent = (cmd_q == CMD_COMMIT) && !drop_q;
        retry_err  = drop_q;
        state_d    = SETTLE;
      end

      SETTLE: begin
        // Gives the FIFO time to present the committed/rewound head word.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      retry_cnt_q <= '0;
      timeout_q   <= '0;
      shift_q     <= '0;
      cmd_q       <= CMD_NONE;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      timeout_q   <= timeout_d;
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      drop_q      <= drop_d;
    end
  end

  assign fifo.fifo_rd_en   = rd_en;
  assign fifo.fifo_command = command;
  assign busy              = (state_q != IDLE);
  assign dbg_state         = state_q;
  assign dbg_retry_cnt     = 8'(retry_cnt_q);

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Bench for tx_frame_serializer: a default instance and an 8-bit/9-word instance,
// each fed by a small FIFO model, checked by bit and command scoreboards.
module tb_tx_frame_serializer;
  import tx_serdes_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] sync_p = 16'hF0A5;

  // ---------------- instance A: defaults ----------------
  logic   en_a, ack_v_a, ack_ok_a;
  logic   txb_a, txv_a, sof_a, fs_a, re_a, busy_a;
  state_t st_a;
  logic [7:0] rc_a;
  tx_frame_serializer_if #(.DATA_WIDTH(32)) fa();

  tx_frame_serializer dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .fifo(fa),
    .ack_valid(ack_v_a), .ack_ok(ack_ok_a),
    .tx_bit(txb_a), .tx_valid(txv_a), .tx_sof(sof_a),
    .frame_sent(fs_a), .retry_err(re_a), .busy(busy_a),
    .dbg_state(st_a), .dbg_retry_cnt(rc_a)
  );

  // ---------------- instance B: 8-bit words, 9 per frame ----------------
  logic   en_b, ack_v_b, ack_ok_b;
  logic   txb_b, txv_b, sof_b, fs_b, re_b, busy_b;
  state_t st_b;
  logic [7:0] rc_b;
  tx_frame_serializer_if #(.DATA_WIDTH(8)) fb();

  tx_frame_serializer #(.DATA_WIDTH(8), .FRAME_WORDS(9)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .fifo(fb),
    .ack_valid(ack_v_b), .ack_ok(ack_ok_b),
    .tx_bit(txb_b), .tx_valid(txv_b), .tx_sof(sof_b),
    .frame_sent(fs_b), .retry_err(re_b), .busy(busy_b),
    .dbg_state(st_b), .dbg_retry_cnt(rc_b)
  );

  // ---------------- FIFO models (head visible 2 cycles after a move) ----------------
  logic [31:0] mem_a [256];
  int wr_pend_a = 0, wr_s1_a = 0, wr_vis_a = 0, rd_a = 0, cm_a = 0;
  logic [31:0] d1_a;
  assign fa.fifo_empty = (rd_a == wr_vis_a);
  always @(posedge clk) begin
    if (fa.fifo_rd_en) rd_a <= rd_a + 1;
    else if (fa.fifo_command == CMD_RESEND) rd_a <= cm_a;
    if (fa.fifo_command == CMD_COMMIT) cm_a <= rd_a;
    d1_a         <= mem_a[rd_a];
    fa.fifo_dout <= d1_a;
    wr_s1_a      <= wr_pend_a;
    wr_vis_a     <= wr_s1_a;
  end

  logic [7:0] mem_b [256];
  int wr_pend_b = 0, wr_s1_b = 0, wr_vis_b = 0, rd_b = 0, cm_b = 0;
  logic [7:0] d1_b;
  assign fb.fifo_empty = (rd_b == wr_vis_b);
  always @(posedge clk) begin
    if (fb.fifo_rd_en) rd_b <= rd_b + 1;
    else if (fb.fifo_command == CMD_RESEND) rd_b <= cm_b;
    if (fb.fifo_command == CMD_COMMIT) cm_b <= rd_b;
    d1_b         <= mem_b[rd_b];
    fb.fifo_dout <= d1_b;
    wr_s1_b      <= wr_pend_b;
    wr_vis_b     <= wr_s1_b;
  end

  task automatic push_a(input logic [31:0] w);
    mem_a[wr_pend_a] = w;
    wr_pend_a++;
  endtask

  task automatic push_b(input logic [7:0] w);
    mem_b[wr_pend_b] = w;
    wr_pend_b++;
  endtask

  // ---------------- scoreboard ----------------
  logic [1:0] exp_a [$];      // {tx_sof, tx_bit}
  logic [1:0] exp_b [$];
  logic [5:0] exp_cmd_a [$];  // {fifo_command, frame_sent, retry_err}
  logic [5:0] exp_cmd_b [$];
  logic [1:0] e_a, e_b;
  logic [5:0] c_a, c_b;
  int rd_cnt_b = 0;

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] != b) r = r ^ 16'h1021;
    return r;
  endfunction

  task automatic exp_frame_a(input logic [31:0] w0, w1, w2, w3);
    logic [31:0] ws [4];
    logic [15:0] c;
    logic        b;
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    c = 16'hFFFF;
    for (int i = 15; i >= 0; i--) exp_a.push_back({(i == 15), sync_p[i]});
    for (int k = 0; k < 4; k++) begin
      for (int j = 31; j >= 0; j--) begin
        b = ws[k][j];
        exp_a.push_back({1'b0, b});
        c = crc_bit(c, b);
      end
    end
    for (int i = 15; i >= 0; i--) exp_a.push_back({1'b0, c[i]});
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (txv_a || sof_a) begin
        n_checks++;
        if (exp_a.size() == 0) begin
          n_err++;
          $display("FAIL a_bit_unexpected: got sof=%0b bit=%0b valid=%0b, no bit expected", sof_a, txb_a, txv_a);
        end else begin
          e_a = exp_a.pop_front();
          if (!txv_a || {sof_a, txb_a} !== e_a) begin
            n_err++;
            $display("FAIL a_bit: got valid=%0b {sof,bit}=%b expected valid=1 %b", txv_a, {sof_a, txb_a}, e_a);
          end
        end
      end
      if (fa.fifo_command != CMD_NONE || fs_a || re_a) begin
        n_checks++;
        if (exp_cmd_a.size() == 0) begin
          n_err++;
          $display("FAIL a_cmd_unexpected: got cmd=%0d frame_sent=%0b retry_err=%0b, none expected", fa.fifo_command, fs_a, re_a);
        end else begin
          c_a = exp_cmd_a.pop_front();
          if ({fa.fifo_command, fs_a, re_a} !== c_a) begin
            n_err++;
            $display("FAIL a_cmd: got {cmd,sent,err}=%b expected %b", {fa.fifo_command, fs_a, re_a}, c_a);
          end
        end
      end
      if (txv_b || sof_b) begin
        n_checks++;
        if (exp_b.size() == 0) begin
          n_err++;
          $display("FAIL b_bit_unexpected: got sof=%0b bit=%0b valid=%0b, no bit expected", sof_b, txb_b, txv_b);
        end else begin
          e_b = exp_b.pop_front();
          if (!txv_b || {sof_b, txb_b} !== e_b) begin
            n_err++;
            $display("FAIL b_bit: got valid=%0b {sof,bit}=%b expected valid=1 %b", txv_b, {sof_b, txb_b}, e_b);
          end
        end
      end
      if (fb.fifo_command != CMD_NONE || fs_b || re_b) begin
        n_checks++;
        if (exp_cmd_b.size() == 0) begin
          n_err++;
          $display("FAIL b_cmd_unexpected: got cmd=%0d frame_sent=%0b retry_err=%0b, none expected", fb.fifo_command, fs_b, re_b);
        end else begin
          c_b = exp_cmd_b.pop_front();
          if ({fb.fifo_command, fs_b, re_b} !== c_b) begin
            n_err++;
            $display("FAIL b_cmd: got {cmd,sent,err}=%b expected %b", {fb.fifo_command, fs_b, re_b}, c_b);
          end
        end
      end
      if (fb.fifo_rd_en) rd_cnt_b++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_st(input bit inst_b, input state_t s, input int budget, input string name);
    int n = 0;
    while (((inst_b ? st_b : st_a) !== s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if ((inst_b ? st_b : st_a) !== s) begin
      n_err++;
      $display("FAIL %s: state %0d not reached within %0d cycles, got %0d", name, s, budget, (inst_b ? st_b : st_a));
    end
  endtask

  task automatic pulse_ack_a(input logic ok);
    ack_v_a  = 1'b1;
    ack_ok_a = ok;
    @(negedge clk);
    ack_v_a  = 1'b0;
    ack_ok_a = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cycles, valids, sofs, stall_bad, n, idle_cmd;
    reset_n = 1'b0;
    en_a = 1'b0; ack_v_a = 1'b0; ack_ok_a = 1'b0;
    en_b = 1'b0; ack_v_b = 1'b0; ack_ok_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_outputs_a", {txb_a, txv_a, sof_a, fs_a, re_a, busy_a, fa.fifo_rd_en, fa.fifo_command}, 0);
    chk("reset_outputs_b", {txb_b, txv_b, sof_b, fs_b, re_b, busy_b, fb.fifo_rd_en, fb.fifo_command}, 0);
    chk("reset_state_a", st_a, IDLE);
    reset_n = 1'b1;

    // Test 1: 8-bit words "123456789", CRC 0x29B1, enable dropped mid-frame.
    for (int i = 0; i < 9; i++) push_b(8'h31 + 8'(i));
    for (int i = 15; i >= 0; i--) exp_b.push_back({(i == 15), sync_p[i]});
    for (int k = 0; k < 9; k++) begin
      logic [7:0] byte_v;
      byte_v = 8'h31 + 8'(k);
      for (int j = 7; j >= 0; j--) exp_b.push_back({1'b0, byte_v[j]});
    end
    begin
      logic [15:0] crc_exp;
      crc_exp = 16'h29B1;
      for (int i = 15; i >= 0; i--) exp_b.push_back({1'b0, crc_exp[i]});
    end
    exp_cmd_b.push_back({CMD_COMMIT, 1'b1, 1'b0});
    repeat (3) @(negedge clk);
    en_b = 1'b1;
    wait_st(1'b1, SYNC, 20, "b_sync_start");
    en_b = 1'b0;
    wait_st(1'b1, WAIT_ACK, 200, "b_wait_ack");
    chk("b_rd_en_pulses", rd_cnt_b, 9);
    chk("b_bits_left", exp_b.size(), 0);
    ack_v_b = 1'b1; ack_ok_b = 1'b1;
    @(negedge clk);
    ack_v_b = 1'b0; ack_ok_b = 1'b0;
    chk("b_cmd_state", st_b, CMD);
    wait_st(1'b1, IDLE, 5, "b_idle");

    // Test 2: default frame timing and ACK -> commit.
    push_a(32'h12345678); push_a(32'hDEADBEEF); push_a(32'h00000000); push_a(32'hFFFFFFFF);
    exp_frame_a(32'h12345678, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF);
    exp_cmd_a.push_back({CMD_COMMIT, 1'b1, 1'b0});
    en_a = 1'b1;
    wait_st(1'b0, SYNC, 20, "a_sync_start");
    cycles = 0; valids = 0; sofs = 0;
    while (st_a !== WAIT_ACK && cycles < 400) begin
      if (txv_a) valids++;
      if (sof_a) sofs++;
      cycles++;
      @(negedge clk);
    end
    chk("a_sof_count", sofs, 1);
    chk("a_valid_cycles", valids, 160);
    chk("a_sync_to_wait_cycles", cycles, 164);
    pulse_ack_a(1'b1);
    chk("a_ack_cmd_state", st_a, CMD);
    chk("a_ack_cmd_code", fa.fifo_command, CMD_COMMIT);
    @(negedge clk);
    chk("a_settle_state", st_a, SETTLE);
    chk("a_settle_cmd_none", fa.fifo_command, CMD_NONE);
    @(negedge clk);
    chk("a_idle_after_cmd", st_a, IDLE);

    // Test 3: stall in LOAD with 2 of 4 words, resume 50 cycles later.
    push_a(32'h12345678); push_a(32'hDEADBEEF);
    exp_frame_a(32'h12345678, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF);
    exp_cmd_a.push_back({CMD_COMMIT, 1'b1, 1'b0});
    wait_st(1'b0, SYNC, 20, "a_stall_sync");
    repeat (82) @(negedge clk);
    stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (st_a !== LOAD || txv_a || fa.fifo_rd_en) stall_bad++;
      @(negedge clk);
    end
    chk("a_stall_in_load", stall_bad, 0);
    chk("a_stall_bits_left", exp_a.size(), 80);
    push_a(32'h00000000); push_a(32'hFFFFFFFF);
    wait_st(1'b0, WAIT_ACK, 200, "a_stall_wait_ack");
    chk("a_stall_bits_done", exp_a.size(), 0);
    pulse_ack_a(1'b1);
    wait_st(1'b0, IDLE, 5, "a_stall_idle");

    // Test 4: NACK -> resend identical frame, then ACK.
    push_a(32'hA5A5A5A5); push_a(32'h0F0F0F0F); push_a(32'h80000001); push_a(32'h7FFFFFFE);
    exp_frame_a(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h80000001, 32'h7FFFFFFE);
    exp_frame_a(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h80000001, 32'h7FFFFFFE);
    exp_cmd_a.push_back({CMD_RESEND, 1'b0, 1'b0});
    exp_cmd_a.push_back({CMD_COMMIT, 1'b1, 1'b0});
    wait_st(1'b0, WAIT_ACK, 200, "a_nack_wait1");
    pulse_ack_a(1'b0);
    chk("a_nack_retry_cnt", rc_a, 1);
    wait_st(1'b0, WAIT_ACK, 200, "a_nack_wait2");
    pulse_ack_a(1'b1);
    chk("a_ack_retry_cleared", rc_a, 0);
    wait_st(1'b0, IDLE, 5, "a_nack_idle");

    // Test 5: timeout/NACK x4 -> drop, next frame uses new data; ack on last timeout cycle wins.
    push_a(32'h11111111); push_a(32'h22222222); push_a(32'h33333333); push_a(32'h44444444);
    push_a(32'hCAFEF00D); push_a(32'h01234567); push_a(32'h89ABCDEF); push_a(32'h55AA55AA);
    for (int r = 0; r < 4; r++) exp_frame_a(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    exp_frame_a(32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 32'h55AA55AA);
    for (int r = 0; r < 3; r++) exp_cmd_a.push_back({CMD_RESEND, 1'b0, 1'b0});
    exp_cmd_a.push_back({CMD_COMMIT, 1'b0, 1'b1});
    exp_cmd_a.push_back({CMD_COMMIT, 1'b1, 1'b0});
    wait_st(1'b0, WAIT_ACK, 200, "a_to_wait1");
    n = 0;
    while (st_a === WAIT_ACK && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk("a_timeout_cycles", n, 1024);
    chk("a_timeout_cmd_state", st_a, CMD);
    wait_st(1'b0, WAIT_ACK, 200, "a_to_wait2");
    pulse_ack_a(1'b0);
    wait_st(1'b0, WAIT_ACK, 200, "a_to_wait3");
    wait_st(1'b0, CMD, 1100, "a_to_timeout3");
    wait_st(1'b0, WAIT_ACK, 200, "a_to_wait4");
    pulse_ack_a(1'b0);
    chk("a_drop_retry_err", re_a, 1);
    chk("a_drop_retry_cnt", rc_a, 0);
    wait_st(1'b0, WAIT_ACK, 200, "a_next_wait");
    repeat (1023) @(negedge clk);
    chk("a_last_timeout_cycle_state", st_a, WAIT_ACK);
    pulse_ack_a(1'b1);
    chk("a_ack_beats_timeout", fs_a, 1);
    wait_st(1'b0, IDLE, 5, "a_to_idle");
    chk("a_frames_done", exp_a.size(), 0);

    // Test 6: reset during DATA of word 2, then ack in IDLE is ignored.
    push_a(32'hFEEDFACE); push_a(32'hBAADF00D); push_a(32'h13579BDF); push_a(32'h2468ACE0);
    exp_frame_a(32'hFEEDFACE, 32'hBAADF00D, 32'h13579BDF, 32'h2468ACE0);
    wait_st(1'b0, SYNC, 20, "a_rst_sync");
    repeat (59) @(negedge clk);
    chk("a_rst_in_data", st_a, DATA);
    reset_n = 1'b0;
    en_a = 1'b0;
    exp_a.delete();
    @(negedge clk);
    chk("a_rst_outputs", {txb_a, txv_a, sof_a, fs_a, re_a, busy_a, fa.fifo_rd_en, fa.fifo_command}, 0);
    chk("a_rst_state", st_a, IDLE);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_ack_a(1'b1);
    idle_cmd = 0;
    for (int i = 0; i < 6; i++) begin
      if (fa.fifo_command != CMD_NONE || st_a !== IDLE) idle_cmd++;
      @(negedge clk);
    end
    chk("a_ack_in_idle_ignored", idle_cmd, 0);

    chk("a_cmd_queue_empty", exp_cmd_a.size(), 0);
    chk("b_cmd_queue_empty", exp_cmd_b.size(), 0);
    chk("b_bit_queue_empty", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
